alu_req_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the single 16-bit saturating ALU between NREQ requesters, e.g. EX-stage issue and the branch/address-calc unit.
- Accepts operations over valid/ready handshakes, registers the winning operation onto the ALU inputs, and captures the ALU's combinational dst/ov/zr/neg.
- Returns the result tagged with the requester ID over a valid/ready response channel with backpressure.
- One operation in flight at a time.

---
 rtl/alu_req_arb_pkg.sv | 32 +++
 rtl/alu_req_arb_rr_pick.sv | 41 ++++
 rtl/alu_req_arb.sv | 202 ++++++++++++++++++++
 tb/tb_alu_req_arb.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_arb_pkg.sv
// Shared definitions for the ALU request arbiter: ALU function codes, FSM
// state encoding and the registered operation bundle.
package alu_req_arb_pkg;

    localparam logic [2:0] FUNC_ADD = 3'b000;
    localparam logic [2:0] FUNC_SUB = 3'b001;
    localparam logic [2:0] FUNC_AND = 3'b010;
    localparam logic [2:0] FUNC_NOR = 3'b011;
    localparam logic [2:0] FUNC_SLL = 3'b100;
    localparam logic [2:0] FUNC_SRL = 3'b101;
    localparam logic [2:0] FUNC_SRA = 3'b110;
    localparam logic [2:0] FUNC_LHB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic [2:0]  func;
        logic [3:0]  shamt;
        logic        padd;
        logic [15:0] src0;
        logic [15:0] src1;
    } alu_op_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_req_arb_rr_pick.sv
// Combinational round-robin picker: grants the first asserted request at or
// above ptr, wrapping around; reusable for any shared-resource arbiter.
module alu_req_arb_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] req2_s;
    logic [NREQ-1:0]   rot_s;
    logic [IDW-1:0]    off_s;
    logic [IDW:0]      sum_s;
    logic              found_s;
    logic              hit_s;

    // Rotate requests so ptr sits at bit 0, find the first one, un-rotate the index
    always_comb begin
        req2_s  = {req, req};
        rot_s   = req2_s[ptr +: NREQ];
        off_s   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            hit_s   = rot_s[k] & ~found_s;
            off_s   = hit_s ? IDW'(k) : off_s;
            found_s = found_s | hit_s;
        end
        sum_s  = {1'b0, ptr} + {1'b0, off_s};
        gnt_id = (sum_s >= NREQ_W) ? IDW'(sum_s - NREQ_W) : sum_s[IDW-1:0];
        for (int j = 0; j < NREQ; j++) begin
            gnt[j] = found_s & (gnt_id == IDW'(j));
        end
    end

endmodule

// File: rtl/alu_req_arb.sv
// Round-robin arbiter/sequencer sharing one 16-bit ALU between NREQ requesters.
// Optional performance counters are built when ALU_ARB_PERF_EN is defined.
module alu_req_arb
    import alu_req_arb_pkg::*;
#(
    parameter int  NREQ      = 2,
    parameter int  IDLE_ZERO = 1,
    localparam int IDW       = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [3*NREQ-1:0]    req_func,
    input  logic [4*NREQ-1:0]    req_shamt,
    input  logic [NREQ-1:0]      req_padd,
    input  logic [16*NREQ-1:0]   req_src0,
    input  logic [16*NREQ-1:0]   req_src1,
    output logic [2:0]           alu_func,
    output logic [3:0]           alu_shamt,
    output logic                 alu_padd,
    output logic [15:0]          alu_src0,
    output logic [15:0]          alu_src1,
    input  logic [15:0]          alu_dst,
    input  logic                 alu_ov,
    input  logic                 alu_zr,
    input  logic                 alu_neg,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_dst,
    output logic                 rsp_ov,
    output logic                 rsp_zr,
    output logic                 rsp_neg
`ifdef ALU_ARB_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [16*NREQ-1:0]   perf_grant_cnt,
    output logic [15:0]          perf_ov_cnt
`endif
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    alu_op_t        op_q, op_d;
    logic           rsp_vld_q, rsp_vld_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]    rsp_dst_q, rsp_dst_d;
    logic [2:0]     rsp_flg_q, rsp_flg_d;

    logic [NREQ-1:0] pick_gnt_s;
    logic [IDW-1:0]  pick_id_s;
    logic [IDW-1:0]  ptr_nxt_s;
    logic            xfer_s;
    alu_op_t         sel_op_s;
    logic            sel_hit_s;

    alu_req_arb_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req_vld),
        .ptr    (ptr_q),
        .gnt    (pick_gnt_s),
        .gnt_id (pick_id_s)
    );

    // Grant only from IDLE; depends on state and req_vld alone
    always_comb begin
        req_rdy   = (state_q == ST_IDLE) ? pick_gnt_s : '0;
        xfer_s    = |(req_vld & req_rdy);
        ptr_nxt_s = (pick_id_s == IDW'(NREQ - 1)) ? '0 : pick_id_s + IDW'(1);
    end

    // Field mux for the round-robin winner
    always_comb begin
        sel_op_s  = '0;
        sel_hit_s = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            sel_hit_s      = (pick_id_s == IDW'(j));
            sel_op_s.func  = sel_hit_s ? req_func[3*j +: 3]   : sel_op_s.func;
            sel_op_s.shamt = sel_hit_s ? req_shamt[4*j +: 4]  : sel_op_s.shamt;
            sel_op_s.padd  = sel_hit_s ? req_padd[j]          : sel_op_s.padd;
            sel_op_s.src0  = sel_hit_s ? req_src0[16*j +: 16] : sel_op_s.src0;
            sel_op_s.src1  = sel_hit_s ? req_src1[16*j +: 16] : sel_op_s.src1;
        end
    end

    // Sequencer next-state: accept, execute for one cycle, then hold the response
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        rsp_vld_d = rsp_vld_q;
        rsp_id_d  = rsp_id_q;
        rsp_dst_d = rsp_dst_q;
        rsp_flg_d = rsp_flg_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    op_d    = sel_op_s;
                    id_d    = pick_id_s;
                    ptr_d   = ptr_nxt_s;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_dst_d = alu_dst;
                rsp_flg_d = {alu_ov, alu_zr, alu_neg};
                rsp_id_d  = id_q;
                rsp_vld_d = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_rdy) begin
                    rsp_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                    // Zeroing the ALU inputs while idle stops operand toggling
                    if (IDLE_ZERO != 0) begin
                        op_d = '0;
                    end else begin
                        op_d = op_q;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_vld_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State, operation and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            op_q      <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            rsp_dst_q <= 16'h0000;
            rsp_flg_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            op_q      <= op_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_dst_q <= rsp_dst_d;
            rsp_flg_q <= rsp_flg_d;
        end
    end

    assign alu_func  = op_q.func;
    assign alu_shamt = op_q.shamt;
    assign alu_padd  = op_q.padd;
    assign alu_src0  = op_q.src0;
    assign alu_src1  = op_q.src1;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_dst   = rsp_dst_q;
    assign rsp_ov    = rsp_flg_q[2];
    assign rsp_zr    = rsp_flg_q[1];
    assign rsp_neg   = rsp_flg_q[0];

`ifdef ALU_ARB_PERF_EN
    logic [16*NREQ-1:0] grant_cnt_q;
    logic [15:0]        ov_cnt_q;

    // Saturating per-requester grant counters and overflow-in-EXEC counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            ov_cnt_q    <= 16'h0000;
        end else if (perf_clr) begin
            grant_cnt_q <= '0;
            ov_cnt_q    <= 16'h0000;
        end else begin
            for (int j = 0; j < NREQ; j++) begin
                if (xfer_s && (pick_id_s == IDW'(j))) begin
                    grant_cnt_q[16*j +: 16] <= sat_inc16(grant_cnt_q[16*j +: 16]);
                end
            end
            if ((state_q == ST_EXEC) && alu_ov) begin
                ov_cnt_q <= sat_inc16(ov_cnt_q);
            end
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_ov_cnt    = ov_cnt_q;
`endif

endmodule

// File: tb/tb_alu_req_arb.sv
// Self-checking bench for alu_req_arb: directed scenarios plus randomized
// traffic against a cycle-level reference model and a behavioural ALU.
module tb_alu_req_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_vld, req_rdy;
    logic [3*NREQ-1:0]   req_func;
    logic [4*NREQ-1:0]   req_shamt;
    logic [NREQ-1:0]     req_padd;
    logic [16*NREQ-1:0]  req_src0, req_src1;
    logic [2:0]          alu_func;
    logic [3:0]          alu_shamt;
    logic                alu_padd;
    logic [15:0]         alu_src0, alu_src1, alu_dst;
    logic                alu_ov, alu_zr, alu_neg;
    logic                rsp_vld, rsp_rdy;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_dst;
    logic                rsp_ov, rsp_zr, rsp_neg;
`ifdef ALU_ARB_PERF_EN
    logic                perf_clr;
    logic [16*NREQ-1:0]  perf_grant_cnt;
    logic [15:0]         perf_ov_cnt;
`endif

    logic        v_vld   [NREQ];
    logic [2:0]  v_func  [NREQ];
    logic [3:0]  v_shamt [NREQ];
    logic        v_padd  [NREQ];
    logic [15:0] v_src0  [NREQ];
    logic [15:0] v_src1  [NREQ];

    int n_chk  = 0;
    int n_pass = 0;
    bit hold   = 1'b0;

    alu_req_arb #(.NREQ(NREQ), .IDLE_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_func(req_func), .req_shamt(req_shamt),
        .req_padd(req_padd), .req_src0(req_src0), .req_src1(req_src1),
        .alu_func(alu_func), .alu_shamt(alu_shamt), .alu_padd(alu_padd),
        .alu_src0(alu_src0), .alu_src1(alu_src1),
        .alu_dst(alu_dst), .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_neg(alu_neg),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_dst(rsp_dst),
        .rsp_ov(rsp_ov), .rsp_zr(rsp_zr), .rsp_neg(rsp_neg)
`ifdef ALU_ARB_PERF_EN
        , .perf_clr(perf_clr), .perf_grant_cnt(perf_grant_cnt), .perf_ov_cnt(perf_ov_cnt)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int j = 0; j < NREQ; j++) begin
            req_vld[j]             = v_vld[j];
            req_func[3*j +: 3]     = v_func[j];
            req_shamt[4*j +: 4]    = v_shamt[j];
            req_padd[j]            = v_padd[j];
            req_src0[16*j +: 16]   = v_src0[j];
            req_src1[16*j +: 16]   = v_src1[j];
        end
    end

    // Behavioural saturating ALU: returns {ov, dst}; SUB is src1 - src0
    function automatic logic [16:0] alu_model(input logic [2:0] f, input logic [3:0] sh,
                                              input logic p, input logic [15:0] a,
                                              input logic [15:0] b);
        int s, hi, lo;
        logic [15:0] d;
        logic ov;
        ov = 1'b0; d = 16'h0000; s = 0; hi = 0; lo = 0;
        if (p) begin
            hi = int'($signed(a[15:8])) + int'($signed(b[15:8]));
            lo = int'($signed(a[7:0]))  + int'($signed(b[7:0]));
            if (hi > 127)  begin hi = 127;  ov = 1'b1; end
            if (hi < -128) begin hi = -128; ov = 1'b1; end
            if (lo > 127)  begin lo = 127;  ov = 1'b1; end
            if (lo < -128) begin lo = -128; ov = 1'b1; end
            d = {8'(hi), 8'(lo)};
        end else if (f <= 3'd1) begin
            s = (f == 3'd0) ? int'($signed(a)) + int'($signed(b))
                            : int'($signed(b)) - int'($signed(a));
            if (s > 32767)  begin s = 32767;  ov = 1'b1; end
            if (s < -32768) begin s = -32768; ov = 1'b1; end
            d = 16'(s);
        end else begin
            case (f)
                3'd2:    d = a & b;
                3'd3:    d = ~(a | b);
                3'd4:    d = a << sh;
                3'd5:    d = a >> sh;
                3'd6:    d = 16'($signed(a) >>> sh);
                default: d = {b[7:0], a[7:0]};
            endcase
        end
        return {ov, d};
    endfunction

    assign {alu_ov, alu_dst} = alu_model(alu_func, alu_shamt, alu_padd, alu_src0, alu_src1);
    assign alu_zr  = (alu_dst == 16'h0000);
    assign alu_neg = alu_dst[15];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model state (spec-level: phase, pointer, captured op, expected response)
    int          m_phase, m_ptr, m_id, m_last_gnt;
    logic [39:0] m_op;
    logic [IDW+18:0] m_rsp;
    int          rsp_log[$];
    logic [39:0] alu_bus;
    logic [IDW+18:0] rsp_bus;
    assign alu_bus = {alu_func, alu_shamt, alu_padd, alu_src0, alu_src1};
    assign rsp_bus = {rsp_id, rsp_dst, rsp_ov, rsp_zr, rsp_neg};

    // Model and per-cycle checks, sampled mid-cycle
    always @(negedge clk) begin : model_proc
        logic [NREQ-1:0] exp_rdy;
        int gnt, idx;
        logic [16:0] r;
        if (!rst_n) begin
            chk("rst_rdy", 64'(req_rdy), 64'(0));
            chk("rst_rsp", 64'({rsp_vld, rsp_bus}), 64'(0));
            chk("rst_alu", 64'(alu_bus), 64'(0));
            m_phase = 0; m_ptr = 0; m_last_gnt = -1;
        end else begin
            gnt = -1;
            if (m_phase == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (gnt < 0 && v_vld[idx]) gnt = idx;
                end
            end
            for (int j = 0; j < NREQ; j++) exp_rdy[j] = (j == gnt);
            chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
            chk("rsp_vld", 64'(rsp_vld), 64'(m_phase == 2));
            if (m_phase == 0) chk("alu_idle", 64'(alu_bus), 64'(0));
            else              chk("alu_hold", 64'(alu_bus), 64'(m_op));
            if (m_phase == 2) chk("rsp_bus", 64'(rsp_bus), 64'(m_rsp));
            m_last_gnt = gnt;
            case (m_phase)
                0: if (gnt >= 0) begin
                       m_op    = {v_func[gnt], v_shamt[gnt], v_padd[gnt], v_src0[gnt], v_src1[gnt]};
                       m_id    = gnt;
                       m_ptr   = (gnt + 1) % NREQ;
                       m_phase = 1;
                   end
                1: begin
                       r = alu_model(m_op[39:37], m_op[36:33], m_op[32], m_op[31:16], m_op[15:0]);
                       m_rsp   = {IDW'(m_id), r[15:0], r[16], (r[15:0] == 16'h0000), r[15]};
                       m_phase = 2;
                   end
                default: if (rsp_rdy) begin
                       rsp_log.push_back(int'(rsp_id));
                       m_phase = 0;
                   end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
        if (m_last_gnt >= 0 && !hold) v_vld[m_last_gnt] = 1'b0;
    endtask

    task automatic set_op(input int r, input logic [2:0] f, input logic [3:0] sh,
                          input logic p, input logic [15:0] a, input logic [15:0] b);
        v_func[r] = f; v_shamt[r] = sh; v_padd[r] = p; v_src0[r] = a; v_src1[r] = b;
        v_vld[r] = 1'b1;
    endtask

    task automatic issue(input int r, input logic [2:0] f, input logic [3:0] sh,
                         input logic p, input logic [15:0] a, input logic [15:0] b);
        bit got;
        got = 1'b0;
        set_op(r, f, sh, p, a, b);
        for (int i = 0; i < 30 && !got; i++) begin
            cyc();
            got = (m_last_gnt == r);
        end
        chk("grant_wait", 64'(got), 64'(1));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_vld) break;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int lat, ngr, c0, c1;
        logic [IDW+18:0] snap;
        rst_n = 1'b0; rsp_rdy = 1'b1;
`ifdef ALU_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        for (int j = 0; j < NREQ; j++) begin
            v_vld[j] = 1'b0; v_func[j] = 3'd0; v_shamt[j] = 4'd0; v_padd[j] = 1'b0;
            v_src0[j] = 16'h0000; v_src1[j] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Single ADD from requester 0
        issue(0, 3'b000, 4'd0, 1'b0, 16'h0003, 16'h0004);
        wait_rsp(lat);
        chk("add_lat", 64'(lat), 64'(2));
        chk("add_id", 64'(rsp_id), 64'(0));
        chk("add_dst", 64'(rsp_dst), 64'(16'h0007));
        chk("add_flags", 64'({rsp_ov, rsp_zr, rsp_neg}), 64'(3'b000));

        // Saturating SUB from requester 1
        issue(1, 3'b001, 4'd0, 1'b0, 16'h0001, 16'h8000);
        wait_rsp(lat);
        chk("sub_lat", 64'(lat), 64'(2));
        chk("sub_id", 64'(rsp_id), 64'(1));
        chk("sub_dst", 64'(rsp_dst), 64'(16'h8000));
        chk("sub_flags", 64'({rsp_ov, rsp_zr, rsp_neg}), 64'(3'b101));
`ifdef ALU_ARB_PERF_EN
        chk("perf_ov", 64'(perf_ov_cnt), 64'(1));
`endif
        cyc();

        // Fairness: both requesters held high for six operations
`ifdef ALU_ARB_PERF_EN
        perf_clr = 1'b1; cyc(); perf_clr = 1'b0;
`endif
        rsp_log.delete();
        hold = 1'b1; ngr = 0;
        set_op(0, 3'b000, 4'd0, 1'b0, 16'h0010, 16'h0001);
        set_op(1, 3'b010, 4'd0, 1'b0, 16'h00FF, 16'h0F0F);
        for (int i = 0; i < 60 && ngr < 6; i++) begin
            cyc();
            if (m_last_gnt >= 0) ngr++;
        end
        hold = 1'b0; v_vld[0] = 1'b0; v_vld[1] = 1'b0;
        for (int i = 0; i < 20 && rsp_log.size() < 6; i++) cyc();
        chk("fair_count", 64'(rsp_log.size()), 64'(6));
        c0 = 0; c1 = 0;
        foreach (rsp_log[i]) begin
            if (i < 6) chk("fair_order", 64'(rsp_log[i]), 64'(i % 2));
            if (rsp_log[i] == 0) c0++; else c1++;
        end
        chk("fair_r0", 64'(c0), 64'(3));
        chk("fair_r1", 64'(c1), 64'(3));
`ifdef ALU_ARB_PERF_EN
        chk("perf_grants", 64'(perf_grant_cnt), 64'({16'd3, 16'd3}));
`endif

        // Backpressure with requester 0 pending behind the held response
        rsp_rdy = 1'b0;
        issue(0, 3'b000, 4'd0, 1'b0, 16'h1234, 16'h0101);
        set_op(0, 3'b010, 4'd0, 1'b0, 16'hF0F0, 16'hFF00);
        wait_rsp(lat);
        chk("bp_dst", 64'(rsp_dst), 64'(16'h1335));
        snap = rsp_bus;
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            chk("bp_hold", 64'({rsp_vld, rsp_bus}), 64'({1'b1, snap}));
            chk("bp_rdy", 64'(req_rdy), 64'(0));
        end
        cyc();
        rsp_rdy = 1'b1;
        cyc();
        @(negedge clk);
        chk("bp_regrant", 64'(req_rdy), 64'(2'b01));
        cyc();
        wait_rsp(lat);
        chk("bp2_lat", 64'(lat), 64'(2));
        chk("bp2_dst", 64'(rsp_dst), 64'(16'hF000));

        // Reset during EXEC discards the operation
        issue(1, 3'b000, 4'd0, 1'b0, 16'h0005, 16'h0006);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmid_vld", 64'(rsp_vld), 64'(0));
        chk("rmid_alu", 64'(alu_bus), 64'(0));
        cyc(); cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rmid_norsp", 64'(rsp_vld), 64'(0));
        end
        set_op(0, 3'b100, 4'd3, 1'b0, 16'h0101, 16'h0000);
        set_op(1, 3'b110, 4'd4, 1'b0, 16'h8000, 16'h0000);
        @(negedge clk);
        chk("rmid_first", 64'(req_rdy), 64'(2'b01));
        repeat (12) cyc();

        // Paired-byte saturating add
        issue(0, 3'b000, 4'd0, 1'b1, 16'h7F80, 16'h0180);
        wait_rsp(lat);
        chk("padd_dst", 64'(rsp_dst), 64'(16'h7F80));
        chk("padd_ov", 64'(rsp_ov), 64'(1));

        // Randomized traffic with random backpressure and request withdrawal
        for (int i = 0; i < 400; i++) begin
            cyc();
            for (int r = 0; r < NREQ; r++) begin
                if (!v_vld[r]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_op(r, 3'($urandom_range(7, 0)), 4'($urandom_range(15, 0)),
                               ($urandom_range(3, 0) == 0), 16'($urandom), 16'($urandom));
                end else if ($urandom_range(19, 0) == 0) begin
                    v_vld[r] = 1'b0;
                end
            end
            rsp_rdy = ($urandom_range(2, 0) != 0);
        end
        for (int r = 0; r < NREQ; r++) v_vld[r] = 1'b0;
        rsp_rdy = 1'b1;
        repeat (10) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
